// File: rtl/ddram_pkg.sv
// Shared types and constants for the DDRAM responder.
package ddram_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LAT_W   = 4;
    localparam int unsigned WIN_W   = 4;

    localparam logic [WIN_W-1:0] WINDOW_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WBURST,
        ST_RWAIT,
        ST_RDATA
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_beat_t;

endpackage

// File: rtl/ddram_mem.sv
// Single-port backing store: byte-enabled writes, registered read data (1-cycle latency).
module ddram_mem
    import ddram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  wr_beat_t          wbeat,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] store_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb rdata_d = store_q[addr];

    // Contents are deliberately not reset so data survives a responder reset.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wbeat.be[b]) begin
                    store_q[addr][8*b +: 8] <= wbeat.data[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddram_responder.sv
// DDRAM-style burst slave: write bursts, fixed-latency read bursts, protocol error flagging.
module ddram_responder
    import ddram_pkg::*;
#(
    parameter int unsigned      ADDR_W = 10,
    parameter int unsigned      RD_LAT = 4,
    parameter logic [WIN_W-1:0] WINDOW = WINDOW_DEFAULT
) (
    input  logic               DDRAM_CLK,
    input  logic               reset_n,
    output logic               DDRAM_BUSY,
    input  logic [BURST_W-1:0] DDRAM_BURSTCNT,
    input  logic [28:0]        DDRAM_ADDR,
    input  logic               DDRAM_RD,
    input  logic               DDRAM_WE,
    input  logic [DATA_W-1:0]  DDRAM_DIN,
    input  logic [BE_W-1:0]    DDRAM_BE,
    output logic [DATA_W-1:0]  DDRAM_DOUT,
    output logic               DDRAM_DOUT_READY,
    input  logic               busy_inject,
    output logic               protocol_err,
    output logic [CNT_W-1:0]   rd_beats,
    output logic [CNT_W-1:0]   wr_beats
);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               drdy_q, drdy_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               perr_q, perr_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BURST_W-1:0] off_q, off_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               oow_q, oow_d;
    logic [CNT_W-1:0]   rdb_q, rdb_d;
    logic [CNT_W-1:0]   wrb_q, wrb_d;

    logic               win_ok_c;
    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  beat_dout_c;
    wr_beat_t           wbeat_c;
    logic               unused_addr_bits;

    assign win_ok_c         = (DDRAM_ADDR[28:25] == WINDOW);
    assign wbeat_c          = '{data: DDRAM_DIN, be: DDRAM_BE};
    assign beat_dout_c      = oow_q ? '0 : mem_rdata;
    assign unused_addr_bits = ^DDRAM_ADDR;

    ddram_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (DDRAM_CLK),
        .we    (mem_we_c),
        .addr  (mem_addr_c),
        .wbeat (wbeat_c),
        .rdata (mem_rdata)
    );

    // Reads are prefetched one cycle ahead (off_q) so the sync RAM meets the exact latency.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        drdy_d     = 1'b0;
        dout_d     = dout_q;
        perr_d     = 1'b0;
        base_d     = base_q;
        off_d      = off_q;
        rem_d      = rem_q;
        lat_d      = lat_q;
        oow_d      = oow_q;
        rdb_d      = rdb_q;
        wrb_d      = wrb_q;
        mem_we_c   = 1'b0;
        mem_addr_c = base_q + ADDR_W'(off_q);

        case (state_q)
            ST_IDLE: begin
                busy_d     = busy_inject;
                mem_addr_c = DDRAM_ADDR[ADDR_W-1:0];
                if (!busy_q && (DDRAM_RD || DDRAM_WE)) begin
                    if (DDRAM_BURSTCNT == '0) begin
                        perr_d = 1'b1;
                    end else begin
                        base_d = DDRAM_ADDR[ADDR_W-1:0];
                        oow_d  = !win_ok_c;
                        perr_d = !win_ok_c || (DDRAM_RD && DDRAM_WE);
                        rem_d  = DDRAM_BURSTCNT - BURST_W'(1);
                        if (DDRAM_WE) begin
                            mem_we_c = win_ok_c;
                            if (win_ok_c) wrb_d = wrb_q + CNT_W'(1);
                            off_d = BURST_W'(1);
                            if (DDRAM_BURSTCNT != BURST_W'(1)) begin
                                state_d = ST_WBURST;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            off_d   = '0;
                            lat_d   = LAT_W'(RD_LAT - 1);
                            state_d = ST_RWAIT;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end
            ST_WBURST: begin
                busy_d = 1'b0;
                if (DDRAM_WE) begin
                    mem_we_c = !oow_q;
                    if (!oow_q) wrb_d = wrb_q + CNT_W'(1);
                    off_d = off_q + BURST_W'(1);
                    rem_d = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = busy_inject;
                    end
                end
            end
            ST_RWAIT: begin
                busy_d = 1'b1;
                if (lat_q <= LAT_W'(1)) off_d = off_q + BURST_W'(1);
                if (lat_q == '0) begin
                    state_d = ST_RDATA;
                    drdy_d  = 1'b1;
                    dout_d  = beat_dout_c;
                    rdb_d   = rdb_q + CNT_W'(1);
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RDATA: begin
                busy_d = 1'b1;
                off_d  = off_q + BURST_W'(1);
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = busy_inject;
                end else begin
                    drdy_d = 1'b1;
                    dout_d = beat_dout_c;
                    rem_d  = rem_q - BURST_W'(1);
                    rdb_d  = rdb_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b1;
            drdy_q  <= 1'b0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            base_q  <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
            oow_q   <= 1'b0;
            rdb_q   <= '0;
            wrb_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            drdy_q  <= drdy_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            base_q  <= base_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            oow_q   <= oow_d;
            rdb_q   <= rdb_d;
            wrb_q   <= wrb_d;
        end
    end

    assign DDRAM_BUSY       = busy_q;
    assign DDRAM_DOUT_READY = drdy_q;
    assign DDRAM_DOUT       = dout_q;
    assign protocol_err     = perr_q;
    assign rd_beats         = rdb_q;
    assign wr_beats         = wrb_q;

endmodule

// File: tb/tb_ddram_responder.sv
// Directed self-checking bench for ddram_responder.
module tb_ddram_responder;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned RD_LAT = 4;

    localparam logic [63:0] W20  = 64'hA5A5_0000_0000_0020;
    localparam logic [63:0] D100 = 64'hCAFE_0000_0000_0100;
    localparam logic [63:0] D200 = 64'h5EED_0000_0000_0200;

    logic        clk;
    logic        reset_n;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic        rd;
    logic        we;
    logic [63:0] din;
    logic [7:0]  be;
    logic [63:0] dout;
    logic        drdy;
    logic        busy_inject;
    logic        perr;
    logic [15:0] rd_beats;
    logic [15:0] wr_beats;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] rbeat [16];
    int          rfirst, rlast, rcnt, rperr;
    logic        rbusy_after;
    logic [15:0] exp_rd, exp_wr;

    ddram_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WINDOW(4'b0011)) dut (
        .DDRAM_CLK        (clk),
        .reset_n          (reset_n),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burstcnt),
        .DDRAM_ADDR       (addr),
        .DDRAM_RD         (rd),
        .DDRAM_WE         (we),
        .DDRAM_DIN        (din),
        .DDRAM_BE         (be),
        .DDRAM_DOUT       (dout),
        .DDRAM_DOUT_READY (drdy),
        .busy_inject      (busy_inject),
        .protocol_err     (perr),
        .rd_beats         (rd_beats),
        .wr_beats         (wr_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Samples outputs for ncyc negedges starting at the current one (c=1 follows the accept edge).
    task automatic collect(input int ncyc);
        rcnt = 0; rfirst = -1; rlast = -1; rperr = 0; rbusy_after = 1'bx;
        for (int c = 1; c <= ncyc; c++) begin
            if (perr === 1'b1) rperr++;
            if (drdy === 1'b1) begin
                if (rfirst < 0) rfirst = c;
                if (rcnt < 16) rbeat[rcnt] = dout;
                rcnt++;
                rlast = c;
            end else if (rlast > 0 && c == rlast + 1) begin
                rbusy_after = busy;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [28:0] a, input logic [7:0] n, input logic [63:0] d,
                            input logic [7:0] b, input int gap, input logic rd_too);
        wait_idle();
        addr = a; burstcnt = n; din = d; be = b; we = 1'b1; rd = rd_too;
        @(negedge clk);
        rd = 1'b0;
        for (int i = 1; i < int'(n); i++) begin
            repeat (gap) begin
                we = 1'b0; rd = 1'b1; addr = 29'h0;
                @(negedge clk);
                check("wburst_busy", 64'(busy), 64'(0));
            end
            rd = 1'b0; we = 1'b1; din = d + 64'(i); addr = 29'h1FFF_FFFF;
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    task automatic do_read(input logic [28:0] a, input logic [7:0] n);
        wait_idle();
        addr = a; burstcnt = n; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        collect(40);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; busy_inject = 1'b0; rd = 1'b0; we = 1'b0;
        burstcnt = 8'd0; addr = '0; din = '0; be = '0;
        exp_rd = '0; exp_wr = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_drdy", 64'(drdy), 64'(0));
        check("rst_dout", dout, 64'(0));
        check("rst_perr", 64'(perr), 64'(0));
        check("rst_rd_beats", 64'(rd_beats), 64'(0));
        check("rst_wr_beats", 64'(wr_beats), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(0));

        // Preset locations used below
        do_write(29'h0600_0010, 8'd1, 64'h0, 8'hFF, 0, 1'b0);
        do_write(29'h0600_0020, 8'd2, W20, 8'hFF, 0, 1'b0);
        do_write(29'h0600_0010, 8'd1, 64'h1122_3344_5566_7788, 8'h0F, 0, 1'b0);
        exp_wr = 16'd4;
        @(negedge clk);
        check("wr_beats_preset", 64'(wr_beats), 64'(exp_wr));

        // Single-beat read, partial byte enables
        do_read(29'h0600_0010, 8'd1);
        exp_rd = exp_rd + 16'd1;
        check("rd1_latency", 64'(rfirst - 1), 64'(RD_LAT));
        check("rd1_count", 64'(rcnt), 64'(1));
        check("rd1_data", rbeat[0], 64'h0000_0000_5566_7788);
        check("rd1_perr", 64'(rperr), 64'(0));
        check("rd1_busy_after", 64'(rbusy_after), 64'(0));

        // Burst-2 read
        do_read(29'h0600_0020, 8'd2);
        exp_rd = exp_rd + 16'd2;
        check("rd2_count", 64'(rcnt), 64'(2));
        check("rd2_consecutive", 64'(rlast - rfirst + 1), 64'(2));
        check("rd2_beat0", rbeat[0], W20);
        check("rd2_beat1", rbeat[1], W20 + 64'd1);
        check("rd2_busy_after", 64'(rbusy_after), 64'(0));
        check("rd2_rd_beats", 64'(rd_beats), 64'(exp_rd));

        // Burst-4 write with WE gaps (RD asserted and ADDR changed in gaps)
        do_write(29'h0600_0100, 8'd4, D100, 8'hFF, 2, 1'b0);
        exp_wr = exp_wr + 16'd4;
        @(negedge clk);
        check("wb4_wr_beats", 64'(wr_beats), 64'(exp_wr));
        check("wb4_rd_ignored", 64'(rd_beats), 64'(exp_rd));
        do_read(29'h0600_0100, 8'd4);
        exp_rd = exp_rd + 16'd4;
        check("wb4_count", 64'(rcnt), 64'(4));
        for (int i = 0; i < 4; i++) check("wb4_word", rbeat[i], D100 + 64'(i));

        // RD and WE together
        do_write(29'h0600_0000, 8'd1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 1'b1);
        exp_wr = exp_wr + 16'd1;
        collect(12);
        check("rdwe_no_drdy", 64'(rcnt), 64'(0));
        check("rdwe_perr", 64'(rperr), 64'(1));
        check("rdwe_wr_beats", 64'(wr_beats), 64'(exp_wr));
        do_read(29'h0600_0000, 8'd1);
        exp_rd = exp_rd + 16'd1;
        check("rdwe_data", rbeat[0], 64'h0123_4567_89AB_CDEF);

        // Zero burst count
        wait_idle();
        addr = 29'h0600_0010; burstcnt = 8'd0; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("bc0_busy", 64'(busy), 64'(0));
        collect(10);
        check("bc0_perr", 64'(rperr), 64'(1));
        check("bc0_no_drdy", 64'(rcnt), 64'(0));
        check("bc0_rd_beats", 64'(rd_beats), 64'(exp_rd));

        // Out-of-window read and write
        do_read(29'h1000_0000, 8'd1);
        exp_rd = exp_rd + 16'd1;
        check("oow_rd_latency", 64'(rfirst - 1), 64'(RD_LAT));
        check("oow_rd_data", rbeat[0], 64'h0);
        check("oow_rd_perr", 64'(rperr), 64'(1));
        check("oow_rd_beats", 64'(rd_beats), 64'(exp_rd));
        do_write(29'h1000_0010, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
        @(negedge clk);
        check("oow_wr_beats", 64'(wr_beats), 64'(exp_wr));
        do_read(29'h0600_0010, 8'd1);
        exp_rd = exp_rd + 16'd1;
        check("oow_wr_dropped", rbeat[0], 64'h0000_0000_5566_7788);

        // busy_inject stalls a pending read
        wait_idle();
        busy_inject = 1'b1;
        @(negedge clk);
        check("inj_busy", 64'(busy), 64'(1));
        addr = 29'h0600_0021; burstcnt = 8'd1; rd = 1'b1;
        repeat (3) @(negedge clk);
        check("inj_busy_held", 64'(busy), 64'(1));
        check("inj_no_drdy", 64'(drdy), 64'(0));
        check("inj_rd_beats", 64'(rd_beats), 64'(exp_rd));
        busy_inject = 1'b0;
        @(negedge clk);
        check("inj_release_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rd = 1'b0;
        collect(20);
        exp_rd = exp_rd + 16'd1;
        check("inj_count", 64'(rcnt), 64'(1));
        check("inj_latency", 64'(rfirst - 1), 64'(RD_LAT));
        check("inj_data", rbeat[0], W20 + 64'd1);

        // Reset in the middle of a burst-8 read
        do_write(29'h0600_0200, 8'd8, D200, 8'hFF, 0, 1'b0);
        wait_idle();
        addr = 29'h0600_0200; burstcnt = 8'd8; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        k = 0;
        while (drdy !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("rst8_drdy_timeout", 64'(drdy), 64'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst8_drdy_now", 64'(drdy), 64'(0));
        check("rst8_busy_now", 64'(busy), 64'(1));
        repeat (3) @(negedge clk);
        check("rst8_drdy_held", 64'(drdy), 64'(0));
        reset_n = 1'b1;
        exp_rd = '0; exp_wr = '0;
        @(negedge clk);
        check("rst8_busy_release", 64'(busy), 64'(0));
        collect(12);
        check("rst8_no_more_beats", 64'(rcnt), 64'(0));
        do_read(29'h0600_0200, 8'd8);
        exp_rd = exp_rd + 16'd8;
        check("rst8_count", 64'(rcnt), 64'(8));
        for (int i = 0; i < 8; i++) check("rst8_word", rbeat[i], D200 + 64'(i));
        check("rst8_rd_beats", 64'(rd_beats), 64'(exp_rd));
        check("rst8_wr_beats", 64'(wr_beats), 64'(exp_wr));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
